// File: rtl/lock_key_pkg.sv
// Shared definitions for the logic-lock key loader: FSM states, CRC-8
// constants, default geometry and the byte-wise CRC-8 update function.
package lock_key_pkg;

    localparam int DEFAULT_KEY_W     = 64;
    localparam int DEFAULT_BYTE_W    = 8;
    localparam int DEFAULT_MAX_FAILS = 3;

    localparam logic [7:0] CRC8_POLY = 8'h07;
    localparam logic [7:0] CRC8_INIT = 8'h00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CHECK,
        ST_COMMIT,
        ST_LOCKOUT
    } state_t;

    // One byte of CRC-8: MSB first, no reflection, no final XOR.
    function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ CRC8_POLY) : {c[6:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/lock_key_crc8.sv
// Combinational CRC-8 update of a running remainder by one data byte.
module lock_key_crc8
    import lock_key_pkg::*;
(
    input  logic [7:0] crc,
    input  logic [7:0] data,
    output logic [7:0] crc_next
);

    // Single-byte advance of the remainder.
    always_comb begin
        crc_next = crc8_byte(crc, data);
    end

endmodule

// File: rtl/lock_key_loader.sv
// Key-provisioning front end for logic-locked cores. Collects a key as a
// little-endian byte stream plus one CRC-8 check byte, then commits the key
// atomically to key_out, or drives an all-zero decoy and flags crc_err.
// Optional lockout after repeated failures: define LOCK_KEY_LOADER_LOCKOUT_EN.
module lock_key_loader
    import lock_key_pkg::*;
#(
    parameter int KEY_W     = DEFAULT_KEY_W,
    parameter int BYTE_W    = DEFAULT_BYTE_W,
    parameter int MAX_FAILS = DEFAULT_MAX_FAILS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [BYTE_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              load_abort,
    output logic [KEY_W-1:0]  key_out,
    output logic              key_ok,
    output logic              crc_err,
    output logic              busy,
    output logic              locked_out
);

    localparam int NBEATS = KEY_W / BYTE_W;
    localparam int BEAT_W = $clog2(NBEATS + 1);

    state_t state_reg;
    state_t state_next;

    logic [KEY_W-1:0]  shadow_reg;
    logic [BEAT_W-1:0] beat_reg;
    logic [7:0]        crc_reg;
    logic [7:0]        crc_upd;
    logic [7:0]        check_reg;

    logic xfer;
    logic shadow_we;
    logic check_we;
    logic clear_load;
    logic commit;
    logic crc_match;
    logic lockout_hit;

    // Handshake and status depend on state only, so they never loop back
    // through the transfer decode.
    assign in_ready  = (state_reg == ST_IDLE) || (state_reg == ST_LOAD) || (state_reg == ST_CHECK);
    assign busy      = (state_reg == ST_LOAD) || (state_reg == ST_CHECK) || (state_reg == ST_COMMIT);
    assign xfer      = in_valid && in_ready;
    assign crc_match = (crc_reg == check_reg);

    lock_key_crc8 u_crc8 (
        .crc      (crc_reg),
        .data     (in_data[7:0]),
        .crc_next (crc_upd)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state decode and datapath strobes; abort wins over a transfer.
    always_comb begin
        state_next = state_reg;
        shadow_we  = 1'b0;
        check_we   = 1'b0;
        clear_load = 1'b0;
        commit     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (xfer) begin
                    shadow_we  = 1'b1;
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (load_abort) begin
                    clear_load = 1'b1;
                    state_next = ST_IDLE;
                end else if (xfer) begin
                    shadow_we = 1'b1;
                    if (beat_reg == BEAT_W'(NBEATS - 1)) begin
                        state_next = ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
                if (load_abort) begin
                    clear_load = 1'b1;
                    state_next = ST_IDLE;
                end else if (xfer) begin
                    check_we   = 1'b1;
                    state_next = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                commit     = 1'b1;
                clear_load = 1'b1;
                state_next = lockout_hit ? ST_LOCKOUT : ST_IDLE;
            end
            ST_LOCKOUT: begin
                state_next = ST_LOCKOUT;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Shadow register, one lane per key byte, written at the current beat.
    for (genvar gi = 0; gi < NBEATS; gi++) begin : g_lane
        // Byte lane gi of the shadow key.
        always_ff @(posedge clk) begin
            if (!rst_n || clear_load) begin
                shadow_reg[gi*BYTE_W +: BYTE_W] <= '0;
            end else if (shadow_we && (beat_reg == BEAT_W'(gi))) begin
                shadow_reg[gi*BYTE_W +: BYTE_W] <= in_data;
            end
        end
    end

    // Beat counter, running CRC, check byte and committed key outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beat_reg  <= '0;
            crc_reg   <= CRC8_INIT;
            check_reg <= '0;
            key_out   <= '0;
            key_ok    <= 1'b0;
            crc_err   <= 1'b0;
        end else begin
            if (clear_load) begin
                beat_reg <= '0;
                crc_reg  <= CRC8_INIT;
            end else if (shadow_we) begin
                beat_reg <= beat_reg + BEAT_W'(1);
                crc_reg  <= crc_upd;
            end
            if (check_we) begin
                check_reg <= in_data[7:0];
            end
            if (commit) begin
                if (crc_match) begin
                    key_out <= shadow_reg;
                    key_ok  <= 1'b1;
                    crc_err <= 1'b0;
                end else begin
                    key_out <= '0;
                    key_ok  <= 1'b0;
                    crc_err <= 1'b1;
                end
            end
        end
    end

`ifdef LOCK_KEY_LOADER_LOCKOUT_EN
    localparam int FAIL_W = $clog2(MAX_FAILS + 1);

    logic [FAIL_W-1:0] fail_cnt_reg;

    // The failure that brings the count up to MAX_FAILS trips the lockout.
    assign lockout_hit = !crc_match && (fail_cnt_reg >= FAIL_W'(MAX_FAILS - 1));
    assign locked_out  = (state_reg == ST_LOCKOUT);

    // Saturating count of consecutive CRC failures.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fail_cnt_reg <= '0;
        end else if (commit) begin
            if (crc_match) begin
                fail_cnt_reg <= '0;
            end else if (fail_cnt_reg != FAIL_W'(MAX_FAILS)) begin
                fail_cnt_reg <= fail_cnt_reg + FAIL_W'(1);
            end
        end
    end
`else
    // Without lockout MAX_FAILS has no effect and failures are unlimited.
    assign lockout_hit = 1'b0 & (MAX_FAILS != 0);
    assign locked_out  = 1'b0;
`endif

endmodule

// File: tb/tb_lock_key_loader.sv
// Directed bench for lock_key_loader: table of full key loads plus
// hand-written sequences for hold-through-load, abort, reset and lockout.
module tb_lock_key_loader;
    import lock_key_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        load_abort;
    logic [63:0] key_out;
    logic        key_ok;
    logic        crc_err;
    logic        busy;
    logic        locked_out;

    int errors = 0;
    int checks = 0;

    lock_key_loader #(.KEY_W(64), .BYTE_W(8), .MAX_FAILS(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .load_abort (load_abort),
        .key_out    (key_out),
        .key_ok     (key_ok),
        .crc_err    (crc_err),
        .busy       (busy),
        .locked_out (locked_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] key;
        logic [7:0]  chk;
        bit          gaps;
        logic [63:0] exp_key;
        logic        exp_ok;
        logic        exp_err;
    } vec_t;

    vec_t vecs[6];

    function automatic logic [7:0] crc_of(input logic [63:0] key);
        logic [7:0] c;
        c = CRC8_INIT;
        for (int i = 0; i < 8; i++) c = crc8_byte(c, key[8*i +: 8]);
        return c;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Present one beat and hold it until it is accepted; returns at edge+1.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int n;
        if (gaps) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        in_data  = b;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            chk("send_timeout", 64'(in_ready), 64'd1);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_key(input logic [63:0] key, input bit gaps);
        for (int i = 0; i < 8; i++) send_byte(key[8*i +: 8], gaps);
    endtask

    // Full load; checks the one-cycle COMMIT bubble and the committed result.
    task automatic do_load(input string tag, input logic [63:0] key, input logic [7:0] cb, input bit gaps,
                           input logic [63:0] exp_key, input logic exp_ok, input logic exp_err);
        send_key(key, gaps);
        send_byte(cb, gaps);
        chk({tag, "_commit_ready"}, 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        chk({tag, "_ready_back"}, 64'(in_ready), 64'd1);
        chk({tag, "_key"}, key_out, exp_key);
        chk({tag, "_ok"}, 64'(key_ok), 64'(exp_ok));
        chk({tag, "_err"}, 64'(crc_err), 64'(exp_err));
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_locked"}, 64'(locked_out), 64'd0);
        $display("load %s key=%h chk=%h -> key_out=%h ok=%0d err=%0d", tag, key, cb, key_out, key_ok, crc_err);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_key"}, key_out, 64'h0);
        chk({tag, "_ok"}, 64'(key_ok), 64'd0);
        chk({tag, "_err"}, 64'(crc_err), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_locked"}, 64'(locked_out), 64'd0);
        chk({tag, "_ready"}, 64'(in_ready), 64'd1);
    endtask

    localparam logic [63:0] K18 = 64'h0807060504030201;
    localparam logic [63:0] KFF = 64'hFFFF_FFFF_FFFF_FFFF;

    initial begin
        logic [7:0] kat;
        logic [7:0] ascii [9];

        rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; load_abort = 1'b0;

        // Known-answer for the CRC-8 reference: "123456789" -> 0xF4.
        ascii = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        kat = CRC8_INIT;
        for (int i = 0; i < 9; i++) kat = crc8_byte(kat, ascii[i]);
        chk("crc8_kat", 64'(kat), 64'hF4);

        vecs[0] = '{64'h0, 8'h00, 1'b0, 64'h0, 1'b1, 1'b0};
        vecs[1] = '{K18, crc_of(K18), 1'b0, K18, 1'b1, 1'b0};
        vecs[2] = '{K18, crc_of(K18), 1'b1, K18, 1'b1, 1'b0};
        vecs[3] = '{KFF, 8'h00, 1'b0, 64'h0, 1'b0, 1'b1};
        vecs[4] = '{K18, crc_of(K18), 1'b1, K18, 1'b1, 1'b0};
        vecs[5] = '{K18, crc_of(K18) ^ 8'h01, 1'b0, 64'h0, 1'b0, 1'b1};

        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_reset_values("reset");

        for (int v = 0; v < 6; v++) begin
            do_load($sformatf("vec%0d", v), vecs[v].key, vecs[v].chk, vecs[v].gaps,
                    vecs[v].exp_key, vecs[v].exp_ok, vecs[v].exp_err);
        end

        // Good key, then a bad reload: old key must hold until COMMIT.
        do_load("good", K18, crc_of(K18), 1'b0, K18, 1'b1, 1'b0);
        send_key(KFF, 1'b0);
        chk("hold_key", key_out, K18);
        chk("hold_ok", 64'(key_ok), 64'd1);
        chk("hold_busy", 64'(busy), 64'd1);
        send_byte(8'h00, 1'b0);
        chk("hold_commit_key", key_out, K18);
        @(posedge clk);
        #1;
        chk("bad_key", key_out, 64'h0);
        chk("bad_ok", 64'(key_ok), 64'd0);
        chk("bad_err", 64'(crc_err), 64'd1);
        $display("reload bad -> key_out=%h ok=%0d err=%0d", key_out, key_ok, crc_err);

        // Abort with the 5th byte valid: byte dropped, nothing committed.
        do_load("pre_abort", K18, crc_of(K18), 1'b0, K18, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) send_byte(8'hA0 + 8'(i), 1'b0);
        in_data = 8'h55; in_valid = 1'b1; load_abort = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0; load_abort = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_key", key_out, K18);
        chk("abort_ok", 64'(key_ok), 64'd1);
        $display("abort -> busy=%0d key_out=%h", busy, key_out);
        do_load("post_abort", 64'h1122334455667788, crc_of(64'h1122334455667788), 1'b0,
                64'h1122334455667788, 1'b1, 1'b0);

        // Reset while waiting for the check byte.
        send_key(64'hDEAD_BEEF_0BAD_F00D, 1'b0);
        chk("pre_rst_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_reset_values("rst_check");
        $display("reset in CHECK -> key_out=%h busy=%0d ready=%0d", key_out, busy, in_ready);
        do_load("post_rst", 64'hA5A4A3A2A1A0_9F9E, crc_of(64'hA5A4A3A2A1A0_9F9E), 1'b0,
                64'hA5A4A3A2A1A0_9F9E, 1'b1, 1'b0);

`ifdef LOCK_KEY_LOADER_LOCKOUT_EN
        // Three consecutive CRC failures lock the loader until reset.
        for (int f = 0; f < 3; f++) begin
            send_key(KFF, 1'b0);
            send_byte(8'h00, 1'b0);
            @(posedge clk);
            #1;
        end
        chk("lock_locked", 64'(locked_out), 64'd1);
        chk("lock_ready", 64'(in_ready), 64'd0);
        chk("lock_key", key_out, 64'h0);
        in_data = 8'h01; in_valid = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("lock_hold", 64'(locked_out), 64'd1);
        chk("lock_ok", 64'(key_ok), 64'd0);
        chk("lock_busy", 64'(busy), 64'd0);
        $display("lockout -> locked=%0d ready=%0d", locked_out, in_ready);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_reset_values("unlock");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
